// File: rtl/gps_ack_pkg.sv
// Shared FSM type, widths and code-phase helper for the GPS acquisition peak detector.
package gps_ack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DECIDE,
    S_REPORT
  } state_t;

  localparam int unsigned CODE_LEN  = 1023;
  localparam int unsigned CP_W      = 10;
  localparam int unsigned DOP_W     = 16;
  localparam int unsigned SAT_W     = 6;
  localparam int unsigned INT_W_DEF = 12;
  localparam int unsigned PWR_W_DEF = 2 * INT_W_DEF;

  // Shortest distance between two code phases on the 1023-chip ring.
  function automatic logic [CP_W-1:0] circ_dist(input logic [CP_W-1:0] cp_a,
                                                input logic [CP_W-1:0] cp_b);
    logic [CP_W-1:0] d;
    logic [CP_W-1:0] wrap;
    d    = (cp_a >= cp_b) ? cp_a - cp_b : cp_b - cp_a;
    wrap = CP_W'(CODE_LEN) - d;
    return (wrap < d) ? wrap : d;
  endfunction

endpackage

// File: rtl/gps_ack_peak_detect_if.sv
// Bin-result input bus and decision output bus of the acquisition peak detector.
interface gps_ack_peak_detect_if #(
  parameter int unsigned INT_W = gps_ack_pkg::INT_W_DEF,
  parameter int unsigned PWR_W = gps_ack_pkg::PWR_W_DEF
);
  logic                                   start;
  logic [gps_ack_pkg::SAT_W-1:0]          sat_in;
  logic                                   corr_valid;
  logic [gps_ack_pkg::CP_W-1:0]           code_phase;
  logic signed [gps_ack_pkg::DOP_W-1:0]   doppler_omega;
  logic signed [INT_W-1:0]                integ_i;
  logic signed [INT_W-1:0]                integ_q;
  logic                                   search_done;

  logic                                   busy;
  logic                                   result_valid;
  logic                                   detected;
  logic [gps_ack_pkg::SAT_W-1:0]          sat_out;
  logic [gps_ack_pkg::CP_W-1:0]           peak_code_phase;
  logic signed [gps_ack_pkg::DOP_W-1:0]   peak_doppler;
  logic [PWR_W-1:0]                       peak_power;
  logic [PWR_W-1:0]                       second_power;

  modport master (
    output start, sat_in, corr_valid, code_phase, doppler_omega, integ_i, integ_q, search_done,
    input  busy, result_valid, detected, sat_out, peak_code_phase, peak_doppler,
           peak_power, second_power
  );

  modport slave (
    input  start, sat_in, corr_valid, code_phase, doppler_omega, integ_i, integ_q, search_done,
    output busy, result_valid, detected, sat_out, peak_code_phase, peak_doppler,
           peak_power, second_power
  );
endinterface

// File: rtl/gps_ack_power.sv
// Two-stage registered I^2 + Q^2 with code-phase/Doppler tags carried alongside.
module gps_ack_power
  import gps_ack_pkg::*;
#(
  parameter int unsigned INT_W = INT_W_DEF,
  parameter int unsigned PWR_W = PWR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [CP_W-1:0]         cp_i,
  input  logic signed [DOP_W-1:0] dop_i,
  input  logic signed [INT_W-1:0] i_i,
  input  logic signed [INT_W-1:0] q_i,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic [CP_W-1:0]         cp_o,
  output logic signed [DOP_W-1:0] dop_o,
  output logic [PWR_W-1:0]        pwr_o
);

  logic signed [2*INT_W-1:0] isq_full;
  logic signed [2*INT_W-1:0] qsq_full;
  logic                      v1_q, v2_q;
  logic [PWR_W-1:0]          isq_q, qsq_q, pwr_q;
  logic [CP_W-1:0]           cp1_q, cp2_q;
  logic signed [DOP_W-1:0]   dop1_q, dop2_q;

  assign isq_full = i_i * i_i;
  assign qsq_full = q_i * q_i;

  // A flush (new search) discards bins still in flight from the previous one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      isq_q  <= '0;
      qsq_q  <= '0;
      pwr_q  <= '0;
      cp1_q  <= '0;
      cp2_q  <= '0;
      dop1_q <= '0;
      dop2_q <= '0;
    end else begin
      v1_q <= valid_i & ~flush_i;
      v2_q <= v1_q & ~flush_i;
      if (valid_i) begin
        isq_q  <= PWR_W'($unsigned(isq_full));
        qsq_q  <= PWR_W'($unsigned(qsq_full));
        cp1_q  <= cp_i;
        dop1_q <= dop_i;
      end
      if (v1_q) begin
        pwr_q  <= isq_q + qsq_q;
        cp2_q  <= cp1_q;
        dop2_q <= dop1_q;
      end
    end
  end

  assign valid_o = v2_q;
  assign busy_o  = v1_q | v2_q;
  assign cp_o    = cp2_q;
  assign dop_o   = dop2_q;
  assign pwr_o   = pwr_q;

endmodule

// File: rtl/gps_ack_peak_detect.sv
// Acquisition peak detector: tracks max and excluded second peak, then issues a detect decision.
module gps_ack_peak_detect
  import gps_ack_pkg::*;
#(
  parameter int unsigned      INT_W      = INT_W_DEF,
  parameter int unsigned      PWR_W      = PWR_W_DEF,
  parameter int unsigned      EXCL_CHIPS = 2,
  parameter logic [7:0]       RATIO_Q4   = 8'd40,
  parameter logic [PWR_W-1:0] MIN_POWER  = 24'd4096
) (
  input  logic                  clk,
  input  logic                  rst,
  gps_ack_peak_detect_if.slave  bus
);

  state_t                  state_q, state_d;
  logic                    pw_valid, pw_busy;
  logic [CP_W-1:0]         pw_cp;
  logic signed [DOP_W-1:0] pw_dop;
  logic [PWR_W-1:0]        pw_pwr;

  logic [PWR_W-1:0]        max_pwr_q, max_pwr_d, sec_pwr_q, sec_pwr_d;
  logic [CP_W-1:0]         max_cp_q, max_cp_d, sec_cp_q, sec_cp_d;
  logic signed [DOP_W-1:0] max_dop_q, max_dop_d;
  logic [SAT_W-1:0]        sat_q, sat_d;
  logic                    det_q, det_d;

  logic                    accept, near_max, near_sec;
  logic [31:0]             ratio_lhs, ratio_rhs;

  assign accept = bus.corr_valid && (state_q == S_ACCUM);

  gps_ack_power #(.INT_W(INT_W), .PWR_W(PWR_W)) u_power (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.start),
    .valid_i (accept),
    .cp_i    (bus.code_phase),
    .dop_i   (bus.doppler_omega),
    .i_i     (bus.integ_i),
    .q_i     (bus.integ_q),
    .valid_o (pw_valid),
    .busy_o  (pw_busy),
    .cp_o    (pw_cp),
    .dop_o   (pw_dop),
    .pwr_o   (pw_pwr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_ACCUM:  if (bus.search_done) state_d = S_DRAIN;
      S_DRAIN:  if (!pw_busy) state_d = S_DECIDE;
      S_DECIDE: state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (bus.start) state_d = S_ACCUM;
  end

  assign near_max  = circ_dist(pw_cp, max_cp_q) <= CP_W'(EXCL_CHIPS);
  assign near_sec  = circ_dist(pw_cp, sec_cp_q) <= CP_W'(EXCL_CHIPS);
  assign ratio_lhs = 32'(max_pwr_q) << 4;
  assign ratio_rhs = 32'(sec_pwr_q) * 32'(RATIO_Q4);

  // A displaced max is demoted to second only when it lies outside the new max's window;
  // a second that falls inside the new window is no longer a valid alias and is dropped.
  always_comb begin
    max_pwr_d = max_pwr_q;
    max_cp_d  = max_cp_q;
    max_dop_d = max_dop_q;
    sec_pwr_d = sec_pwr_q;
    sec_cp_d  = sec_cp_q;
    sat_d     = sat_q;
    det_d     = det_q;
    if (bus.start) begin
      max_pwr_d = '0;
      max_cp_d  = '0;
      max_dop_d = '0;
      sec_pwr_d = '0;
      sec_cp_d  = '0;
      sat_d     = bus.sat_in;
      det_d     = 1'b0;
    end else begin
      if (pw_valid) begin
        if (pw_pwr > max_pwr_q) begin
          max_pwr_d = pw_pwr;
          max_cp_d  = pw_cp;
          max_dop_d = pw_dop;
          if (!near_max) begin
            sec_pwr_d = max_pwr_q;
            sec_cp_d  = max_cp_q;
          end else if (near_sec) begin
            sec_pwr_d = '0;
            sec_cp_d  = '0;
          end
        end else if ((pw_pwr > sec_pwr_q) && !near_max) begin
          sec_pwr_d = pw_pwr;
          sec_cp_d  = pw_cp;
        end
      end
      if (state_q == S_DECIDE)
        det_d = (max_pwr_q > MIN_POWER) && (ratio_lhs >= ratio_rhs);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      max_pwr_q <= '0;
      max_cp_q  <= '0;
      max_dop_q <= '0;
      sec_pwr_q <= '0;
      sec_cp_q  <= '0;
      sat_q     <= '0;
      det_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_pwr_q <= max_pwr_d;
      max_cp_q  <= max_cp_d;
      max_dop_q <= max_dop_d;
      sec_pwr_q <= sec_pwr_d;
      sec_cp_q  <= sec_cp_d;
      sat_q     <= sat_d;
      det_q     <= det_d;
    end
  end

  assign bus.busy            = (state_q == S_ACCUM) || (state_q == S_DRAIN) || (state_q == S_DECIDE);
  assign bus.result_valid    = (state_q == S_REPORT);
  assign bus.detected        = det_q;
  assign bus.sat_out         = sat_q;
  assign bus.peak_code_phase = max_cp_q;
  assign bus.peak_doppler    = max_dop_q;
  assign bus.peak_power      = max_pwr_q;
  assign bus.second_power    = sec_pwr_q;

endmodule

// File: doc/gps_ack_peak_detect.md
Name: gps_ack_peak_detect

Overview:
- Downstream of the acquisition correlator.
- Consumes one (I, Q) integrator result per code-phase/Doppler bin and squares it to a power.
- Tracks the strongest bin and a second peak that excludes the main peak's code-phase neighbourhood.
- At end of a satellite search, issues a detect/no-detect decision plus peak coordinates to the tracking-loop handover logic.

Parameters:
- INT_W, 12, signed width of integ_i/integ_q
- PWR_W, 24, power width (2*INT_W)
- EXCL_CHIPS, 2, ± code-phase exclusion window around max for second peak (circular, mod 1023)
- RATIO_Q4, 8'd40, peak/second threshold in Q4.4 (40 = 2.5)
- MIN_POWER, 24'd4096, absolute floor a peak must exceed

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  pulse: clear trackers, begin new satellite search
- sat_in  in  6  PRN under search, latched on start
- corr_valid  in  1  pulse: one bin result present this cycle
- code_phase  in  10  bin code phase, 0..1022
- doppler_omega  in  16 signed  bin Doppler NCO word
- integ_i  in  INT_W signed  coherent I sum
- integ_q  in  INT_W signed  coherent Q sum
- search_done  in  1  pulse: last bin issued
- busy  out  1  high from start until result_valid
- result_valid  out  1  one-cycle pulse with decision
- detected  out  1  decision
- sat_out  out  6  latched PRN
- peak_code_phase  out  10  code phase of max
- peak_doppler  out  16 signed  Doppler of max
- peak_power  out  PWR_W  max power
- second_power  out  PWR_W  second peak power

Behaviour:
- Reset: all outputs and internal registers 0; state IDLE.
- FSM states: IDLE, ACCUM, DRAIN, DECIDE, REPORT.
  - IDLE -> ACCUM on start.
  - ACCUM -> DRAIN on search_done.
  - DRAIN -> DECIDE when the pipeline is empty.
  - DECIDE -> REPORT after 1 cycle.
  - REPORT -> IDLE after 1 cycle.
  - start in any state aborts, clears trackers and enters ACCUM (start has priority).
- Start clears max/second power to 0, peak_code_phase to 0 and peak_doppler to 0; latches sat_in; busy=1.
- Power pipeline, accepted in ACCUM only; corr_valid is ignored in other states.
  - Stage 1: register i², q² and tags.
  - Stage 2: register p = i² + q² (unsigned, PWR_W).
  - Stage 3: tracker update.
  - Bin-to-tracker latency is 3 cycles; one bin per cycle is sustainable.
  - −2048² fits: 4194304 × 2 < 2^24.
- Exclusion test: d = |cp − max_cp|, then d = min(d, 1023 − d); the bin is "near" when d ≤ EXCL_CHIPS. Proximity ignores Doppler.
- Tracker update for power p at cp:
  - p > max (strict): new max = (p, cp, dop). The old max becomes second only if it is not near cp. Otherwise second is kept unless second is also near cp, in which case second is cleared to 0.
  - else if p > second and not near max_cp: second = p.
  - Ties keep the earlier bin.
- corr_valid together with search_done: the bin is accepted, then DRAIN begins.
- DRAIN waits until stages 1–3 are empty.
- DECIDE: detected = (max > MIN_POWER) && (max×16 ≥ second×RATIO_Q4). Both sides are computed at 32 bits unsigned.
- REPORT: result_valid=1 for one cycle; busy drops in the same cycle.
- Outputs hold their value until the next start.
- Reset mid-search: immediate return to IDLE with all outputs 0; no result_valid is issued.

Decomposition:
- gps_ack_pkg holds:
  - typedef enum state_t for the FSM
  - localparam CODE_LEN=1023
  - power width localparams
  - function circ_dist(cp_a, cp_b)
- Sub-module gps_ack_power: 2-stage registered i²+q² with a valid/tag pass-through (code_phase, doppler).

Test Plan:
- Single bin: start, one bin cp=100, dop=13, I=200, Q=−100, then search_done -> result_valid 5 cycles after the bin's corr_valid. Expected peak_power=50000, second=0, detected=1, peak_code_phase=100.
- Exclusion: bins cp=500 p=90000 (I=300,Q=0), cp=501 p=40000, cp=800 p=10000 -> second_power=10000, detected=1 (90000×16 ≥ 10000×40).
- Circular wrap: max at cp=1022 (I=300), bin cp=0 I=250 -> bin at cp=0 is excluded; second stays 0. Expected peak_code_phase=1022.
- Threshold fail: max I=100 (10000) at cp=10, second I=80 (6400) at cp=400 -> 160000 < 256000, detected=0.
- Tie/min floor: two bins I=60 (3600) at cp=5 and cp=700 -> peak_code_phase=5, second=3600; detected=0 because 3600 ≤ MIN_POWER.
- Abort/reset: start mid-ACCUM after a strong bin -> trackers cleared, new search reports only later bins. Separately, rst low mid-DRAIN -> no result_valid, all outputs 0.
